// File: rtl/boron_enc_core.sv
`timescale 1ns/1ps
// boron_enc_core
//   Iterative BORON encryption datapath and round controller. It runs one
//   round per clock over a 64-bit block, then applies a final whitening XOR.
//   It drives the downstream key schedule: it loads the master key while
//   idle, then steps the schedule's round counter so that the matching round
//   key arrives on ks_rk in every cycle.
//
//   Parameters:
//     ROUNDS      number of full rounds (default 25). The whitening key is
//                 RK(ROUNDS+1).
//
//   Ports:
//     clk         clock, rising edge
//     reset       synchronous, active-high
//     start       request, sampled only in IDLE
//     plaintext   64-bit block, captured on the accepted start edge
//     key         128-bit master key, must be stable while start=1
//     busy        high from the cycle after acceptance until done
//     done        one-cycle pulse when ciphertext is valid
//     ciphertext  last result, held until the next done
//     ks_select   key schedule select (1 = load ks_key_in)
//     ks_key_in   combinational copy of key
//     ks_count    key schedule round counter
//     ks_rk       current round key from the key schedule
//     abort       cancels a running operation (BORON_ABORT_EN builds only)
//
//   Build option:
//     BORON_ABORT_EN  adds the abort port. When it is undefined, a running
//                     operation can only be cut short by reset.
module boron_enc_core #(
  parameter int ROUNDS = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [63:0]  plaintext,
  input  logic [127:0] key,
`ifdef BORON_ABORT_EN
  input  logic         abort,
`endif
  input  logic [63:0]  ks_rk,
  output logic         busy,
  output logic         done,
  output logic [63:0]  ciphertext,
  output logic         ks_select,
  output logic [127:0] ks_key_in,
  output logic [4:0]   ks_count
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);
  // Per-word rotate-left amounts, indexed by word number W0..W3.
  localparam int ROT [4] = '{1, 4, 7, 9};

  fsm_t        fsm_reg;
  logic [4:0]  round_reg;
  logic [63:0] state_reg;

  // Modified BORON S-box, nibble bit 3 is the MSB input.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hE;  4'h1: y = 4'h4;  4'h2: y = 4'hB;  4'h3: y = 4'h1;
      4'h4: y = 4'h7;  4'h5: y = 4'h9;  4'h6: y = 4'hC;  4'h7: y = 4'hA;
      4'h8: y = 4'hD;  4'h9: y = 4'h2;  4'hA: y = 4'h0;  4'hB: y = 4'hF;
      4'hC: y = 4'h8;  4'hD: y = 4'h5;  4'hE: y = 4'h3;  default: y = 4'h6;
    endcase
    return y;
  endfunction

  // ---------------- round function ----------------
  logic [63:0] keyed;
  logic [63:0] subst;
  logic [15:0] perm [4];
  logic [15:0] l0, l1, l2, l3;
  logic [63:0] round_out;

  assign keyed = state_reg ^ ks_rk;

  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    assign subst[gi*4 +: 4] = sbox(keyed[gi*4 +: 4]);
  end

  // Byte swap inside each word, then a per-word rotate-left.
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    logic [15:0] swapped;
    assign swapped  = {subst[gi*16 +: 8], subst[gi*16+8 +: 8]};
    assign perm[gi] = (swapped << ROT[gi]) | (swapped >> (16 - ROT[gi]));
  end

  // Linear layer: each XOR consumes the already-updated words.
  assign l1 = perm[1] ^ perm[0];
  assign l2 = perm[2] ^ l1;
  assign l3 = perm[3] ^ perm[0];
  assign l0 = perm[0] ^ l3;
  assign round_out = {l3, l2, l1, l0};

  // ---------------- key schedule control ----------------
  // While idle the schedule keeps reloading the key, so RK1 is ready in the
  // first ROUND cycle. During round r the schedule steps to RK(r+1).
  assign ks_key_in = key;
  assign ks_select = (fsm_reg == IDLE);
  assign ks_count  = (fsm_reg == ROUND) ? round_reg : 5'd0;

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg    <= IDLE;
      round_reg  <= 5'd0;
      state_reg  <= 64'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ciphertext <= 64'd0;
    end else begin
      done <= 1'b0;
      case (fsm_reg)
        IDLE: begin
          if (start) begin
            state_reg <= plaintext;
            round_reg <= 5'd1;
            busy      <= 1'b1;
            fsm_reg   <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          if (round_reg == LAST_ROUND) begin
            round_reg <= 5'd0;
            fsm_reg   <= FINAL;
          end else begin
            round_reg <= round_reg + 5'd1;
          end
        end
        FINAL: begin
          ciphertext <= state_reg ^ ks_rk;
          done       <= 1'b1;
          busy       <= 1'b0;
          fsm_reg    <= IDLE;
        end
        default: fsm_reg <= IDLE;
      endcase
`ifdef BORON_ABORT_EN
      // Abandon the operation: no done, ciphertext keeps its old value.
      if (abort && fsm_reg != IDLE) begin
        fsm_reg    <= IDLE;
        round_reg  <= 5'd0;
        busy       <= 1'b0;
        done       <= 1'b0;
        ciphertext <= ciphertext;
      end
`endif
    end
  end

endmodule

// File: tb/tb_boron_enc_core.sv
`timescale 1ns/1ps
module tb_boron_enc_core;

  localparam int ROUNDS = 25;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [63:0]  plaintext;
  logic [127:0] key;
  logic         abort;
  logic [63:0]  ks_rk;
  logic         busy;
  logic         done;
  logic [63:0]  ciphertext;
  logic         ks_select;
  logic [127:0] ks_key_in;
  logic [4:0]   ks_count;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q [$];
  logic [63:0] exp_rk [0:27];
  logic [63:0] last_ct;
  logic [127:0] ks_reg;

  always #5 clk = ~clk;

  boron_enc_core #(.ROUNDS(ROUNDS)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .plaintext(plaintext),
    .key(key),
`ifdef BORON_ABORT_EN
    .abort(abort),
`endif
    .ks_rk(ks_rk),
    .busy(busy),
    .done(done),
    .ciphertext(ciphertext),
    .ks_select(ks_select),
    .ks_key_in(ks_key_in),
    .ks_count(ks_count)
  );

  // ---------------- reference models ----------------
  logic [3:0] sb_tab [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                              4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
    return 16'((v << n) | (v >> (16 - n)));
  endfunction

  // Behavioural key schedule sitting behind the DUT.
  function automatic logic [127:0] ks_next(input logic [127:0] k, input logic [4:0] cnt);
    logic [127:0] t;
    t = {k[114:0], k[127:115]};
    t[3:0] = sb_tab[t[3:0]];
    t[63:59] = t[63:59] ^ cnt;
    return t;
  endfunction

  always @(posedge clk) begin
    if (reset) ks_reg <= '0;
    else if (ks_select) ks_reg <= ks_key_in;
    else ks_reg <= ks_next(ks_reg, ks_count);
  end
  assign ks_rk = ks_reg[63:0];

  function automatic logic [63:0] model_round(input logic [63:0] x);
    logic [63:0] s;
    logic [15:0] w [4];
    for (int n = 0; n < 16; n++) s[n*4 +: 4] = sb_tab[x[n*4 +: 4]];
    for (int i = 0; i < 4; i++) begin
      w[i] = s[i*16 +: 16];
      w[i] = {w[i][7:0], w[i][15:8]};
      case (i)
        0: w[i] = rotl16(w[i], 1);
        1: w[i] = rotl16(w[i], 4);
        2: w[i] = rotl16(w[i], 7);
        default: w[i] = rotl16(w[i], 9);
      endcase
    end
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[0];
    w[0] = w[0] ^ w[3];
    return {w[3], w[2], w[1], w[0]};
  endfunction

  // Fills exp_rk[1..ROUNDS+1] and returns the expected ciphertext.
  task automatic model_encrypt(input logic [63:0] pt, input logic [127:0] k,
                               output logic [63:0] ct);
    logic [127:0] kr;
    logic [63:0] st;
    kr = k;
    exp_rk[1] = kr[63:0];
    for (int i = 1; i <= ROUNDS; i++) begin
      kr = ks_next(kr, 5'(i));
      exp_rk[i+1] = kr[63:0];
    end
    st = pt;
    for (int i = 1; i <= ROUNDS; i++) st = model_round(st ^ exp_rk[i]);
    ct = st ^ exp_rk[ROUNDS+1];
  endtask

  // Drives one accepted start edge and queues the expected result.
  task automatic start_op(input logic [63:0] pt, input logic [127:0] k);
    logic [63:0] ct;
    model_encrypt(pt, k, ct);
    exp_q.push_back(ct);
    plaintext = pt;
    key = k;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    plaintext = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (ciphertext !== 64'd0) begin n_err++; $display("FAIL reset_ct: got %h expected 0", ciphertext); end
    n_vec++; if (ks_select !== 1'b1) begin n_err++; $display("FAIL reset_ks_select: got %b expected 1", ks_select); end
    n_vec++; if (ks_count !== 5'd0) begin n_err++; $display("FAIL reset_ks_count: got %0d expected 0", ks_count); end
    last_ct = 64'd0;
    $display("reset: busy=%b done=%b ct=%h", busy, done, ciphertext);
  endtask

  task automatic test_encrypt(input logic [63:0] pt, input logic [127:0] k, input string name);
    logic [63:0] e;
    start_op(pt, k);
    for (int c = 0; c <= ROUNDS + 1; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c <= ROUNDS) begin
        n_vec++; if (ks_rk !== exp_rk[c+1]) begin n_err++; $display("FAIL %s_rk%0d: got %h expected %h", name, c+1, ks_rk, exp_rk[c+1]); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL %s_early_done c=%0d: got %b expected 0", name, c, done); end
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s_busy c=%0d: got %b expected 1", name, c, busy); end
      end
      if (c < ROUNDS) begin
        n_vec++; if (ks_count !== 5'(c+1)) begin n_err++; $display("FAIL %s_ks_count c=%0d: got %0d expected %0d", name, c, ks_count, c+1); end
      end
      if (c == ROUNDS) begin
        n_vec++; if (ks_count !== 5'd0 || ks_select !== 1'b0) begin n_err++; $display("FAIL %s_final_ks: got count=%0d sel=%b expected 0/0", name, ks_count, ks_select); end
      end
      if (c == ROUNDS + 1) begin
        n_vec++;
        if (done !== 1'b1) begin
          n_err++; $display("FAIL %s_done: got %b expected 1", name, done);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          n_err++; $display("FAIL %s_scoreboard: got done with empty queue expected entry", name);
        end else begin
          e = exp_q.pop_front();
          n_vec++; if (ciphertext !== e) begin n_err++; $display("FAIL %s_ct: got %h expected %h", name, ciphertext, e); end
          last_ct = e;
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_busy_at_done: got %b expected 0", name, busy); end
        $display("%s: pt=%h ct=%h", name, pt, ciphertext);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [63:0] e;
    int dones;
    dones = 0;
    start_op(64'h1122_3344_5566_7788, 128'h0F0E0D0C0B0A09080706050403020100);
    for (int c = 1; c <= ROUNDS + 5; c++) begin
      start = (c == 5 || c == 20);
      @(posedge clk); #1;
      start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        n_vec++; if (c != ROUNDS + 1) begin n_err++; $display("FAIL ignore_done_cycle: got %0d expected %0d", c, ROUNDS + 1); end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_vec++; if (ciphertext !== e) begin n_err++; $display("FAIL ignore_ct: got %h expected %h", ciphertext, e); end
          last_ct = e;
        end
      end
    end
    n_vec++; if (dones != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d expected 1", dones); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ignore_restart: got busy=%b expected 0", busy); end
    $display("ignore_start: dones=%0d ct=%h", dones, ciphertext);
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    start_op(64'hDEAD_BEEF_0BAD_F00D, 128'h13579BDF02468ACE_FDB97531ECA86420);
    for (int c = 1; c < 11; c++) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(exp_q.pop_front());
    last_ct = 64'd0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_vec++; if (ks_select !== 1'b1 || ks_count !== 5'd0) begin n_err++; $display("FAIL midreset_ks: got sel=%b count=%0d expected 1/0", ks_select, ks_count); end
    n_vec++; if (ciphertext !== 64'd0) begin n_err++; $display("FAIL midreset_ct: got %h expected 0", ciphertext); end
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL midreset_done: got %0d pulses expected 0", dones); end
    $display("reset_mid: busy=%b ct=%h", busy, ciphertext);
    test_encrypt(64'hDEAD_BEEF_0BAD_F00D, 128'h13579BDF02468ACE_FDB97531ECA86420, "after_reset");
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    start_op(64'h0000_0000_0000_0001, 128'h1);
    for (int c = 1; c <= ROUNDS + 1; c++) begin @(posedge clk); #1; end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_a: got %b expected 1", done); end
    e = exp_q.pop_front();
    n_vec++; if (ciphertext !== e) begin n_err++; $display("FAIL b2b_ct_a: got %h expected %h", ciphertext, e); end
    $display("b2b_a: ct=%h", ciphertext);
    // start held high during the done cycle must be accepted
    start_op(64'h8000_0000_0000_0000, {64'hCAFEBABE_0000_FFFF, 64'h0123_4567_89AB_CDEF});
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    for (int c = 1; c <= ROUNDS + 1; c++) begin @(posedge clk); #1; end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done_b: got %b expected 1", done); end
    e = exp_q.pop_front();
    n_vec++; if (ciphertext !== e) begin n_err++; $display("FAIL b2b_ct_b: got %h expected %h", ciphertext, e); end
    last_ct = e;
    $display("b2b_b: ct=%h", ciphertext);
  endtask

`ifdef BORON_ABORT_EN
  task automatic test_abort;
    int dones;
    dones = 0;
    start_op(64'h5555_AAAA_5555_AAAA, 128'hFFFF);
    for (int c = 1; c < 9; c++) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    void'(exp_q.pop_front());
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_vec++; if (ciphertext !== last_ct) begin n_err++; $display("FAIL abort_ct: got %h expected %h", ciphertext, last_ct); end
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    n_vec++; if (dones != 0) begin n_err++; $display("FAIL abort_done: got %0d pulses expected 0", dones); end
    $display("abort: busy=%b ct=%h", busy, ciphertext);
  endtask
`endif

  initial begin
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    plaintext = '0;
    key = '0;
    last_ct = '0;
    test_reset();
    test_encrypt(64'd0, 128'd0, "zero");
    test_encrypt(64'hFFFF_0000_A5A5_5A5A, 128'h0123456789ABCDEF_FEDCBA9876543210, "vector");
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef BORON_ABORT_EN
    test_abort();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boron_enc_core.md
# boron_enc_core

Iterative BORON encryption datapath and round controller. It sits directly downstream of the key-schedule stage (`key_boron`) and drives it: it loads the master key, steps the schedule's round counter, and consumes the 64-bit round key every cycle. It runs 25 rounds plus final whitening over a 64-bit block, one round per clock.

## Interface
Parameters:
- `ROUNDS`, default 25: number of full rounds; the whitening key is RK(ROUNDS+1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request; sampled only in IDLE.
- `plaintext`  in  64: captured on the accepted `start` edge.
- `key`  in  128: master key; must be stable while `start`=1.
- `busy`  out  1: high from the cycle after acceptance until `done`.
- `done`  out  1: one-cycle pulse when `ciphertext` is valid.
- `ciphertext`  out  64: holds the last result until the next `done`.
- `ks_select`  out  1: to key schedule `select`; 1 loads `ks_key_in`.
- `ks_key_in`  out  128: combinational pass-through of `key`.
- `ks_count`  out  5: to key schedule `count`.
- `ks_rk`  in  64: `RKi` from the key schedule (current round key).
- `abort`  in  1: present only with `BORON_ABORT_EN`.

## Operation
- FSM states: IDLE, ROUND, FINAL.
- **IDLE**
  - `ks_select`=1 and `ks_count`=0.
  - On `start`=1: latch `plaintext` into the 64-bit state register, set round counter r=1, go to ROUND.
  - The key schedule latches `key` on the same edge, so RK1 is on `ks_rk` in the first ROUND cycle.
- **ROUND** (r = 1..ROUNDS)
  - `ks_select`=0 and `ks_count`=r, so the schedule advances to RK(r+1) on the edge.
  - Update: state ← L(P(B(S(state ^ ks_rk)))).
  - r increments each cycle; after r=ROUNDS, go to FINAL.
- **FINAL**
  - `ks_select`=0, `ks_count`=0.
  - Update: `ciphertext` ← state ^ `ks_rk` (RK26), `done` ← 1, go to IDLE.
- **Round function**, with words W3..W0 = state[63:48]..[15:0]:
  - S: 16 instances of the team's modified `boronSbox`, one per nibble. Nibble bit 3 maps to sbox input a (MSB).
  - B (block shuffle): swap the bytes inside each 16-bit word.
  - P (rotate-left per word): W0 by 1, W1 by 4, W2 by 7, W3 by 9.
  - L (applied in order): W1 ^= W0; W2 ^= W1; W3 ^= W0; W0 ^= W3, where each XOR uses the already-updated values.
- `start` outside IDLE is ignored; no queueing.
- `key` and `plaintext` may change freely after acceptance.

## Timing
- Reset values:
  - State = IDLE; r=0.
  - `busy`=0, `done`=0, `ciphertext`=0.
  - `ks_select`=1, `ks_count`=0.
  - State register = 0.
- If `start` is accepted at edge E0:
  - ROUND cycles are E0+1 .. E0+25.
  - FINAL runs in the cycle after E0+25.
  - `done`=1 and `ciphertext` are valid in the cycle after edge E0+26, i.e. 27 cycles after `start`.
- `busy` is 1 from E0 until the edge that raises `done`. It is 0 in the `done` cycle.
- Back-to-back operation: `start` held high while `done`=1 is accepted in that same cycle (FSM is in IDLE).
- `reset` mid-operation: returns to IDLE in one cycle, clears `ciphertext`, and produces no `done`.
- `reset` and `start` asserted together: reset wins.
- All outputs are registered except `ks_key_in`, `ks_select` and `ks_count`, which are decoded from FSM state and r.

## Configuration
- `BORON_ABORT_EN` defined:
  - Adds the `abort` port.
  - `abort`=1 in ROUND or FINAL returns the FSM to IDLE on the next edge.
  - `busy`→0, no `done`, `ciphertext` unchanged.
  - `abort` in IDLE has no effect.
  - `abort` together with `start` in IDLE: the start is accepted.
- Not defined: no `abort` port; an operation can only be cut short by `reset`.

## Test plan
- Reset: after `reset` → `busy`=0, `done`=0, `ciphertext`=0, `ks_select`=1, `ks_count`=0.
- `key`=0, `plaintext`=0, `start` pulse → `done` exactly 27 cycles later. `ks_count` runs 1,2,…,25 then 0. `ciphertext` equals the golden C model.
- `key`=0x0123456789ABCDEF_FEDCBA9876543210, `plaintext`=0xFFFF_0000_A5A5_5A5A → `ciphertext` matches the golden model. The bench compares `ks_rk` against the model's RK1..RK26 every cycle.
- `start` re-pulsed at cycles 5 and 20 of an operation → ignored: single `done` at cycle 27, result unchanged.
- `reset` at cycle 12 → IDLE next cycle, no `done`. A new `start` afterwards completes normally with the correct ciphertext.
- With `BORON_ABORT_EN`: `abort` at cycle 10 → `busy`=0 next cycle, no `done`, prior `ciphertext` retained.
